// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word request, one-entry output buffer to IDU.
// Latency: response latency + 1 cycle from accepted request to valid inst (3 cycles/inst with 0-wait memory).
// Backpressure: pipe_stop freezes the buffered instruction; redirect_valid overrides everything.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_stop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req_valid,
    output logic [31:0] inst_req_addr,
    input  logic        inst_req_ready,
    input  logic        inst_rsp_valid,
    input  logic [31:0] inst_rsp_data,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_clear
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic        r_out_valid;
    logic [31:0] r_out_inst;
    logic [31:0] r_out_pc;
    logic        r_drop;

    state_t      w_state_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic        w_out_valid_nxt;
    logic [31:0] w_out_inst_nxt;
    logic [31:0] w_out_pc_nxt;
    logic        w_drop_nxt;

    logic        w_handshake;
    logic [31:0] w_redirect_aligned;

    assign w_handshake        = (r_state == S_REQ) && inst_req_ready;
    assign w_redirect_aligned = redirect_pc & ~32'h3;

    assign inst_req_valid = (r_state == S_REQ);
    assign inst_req_addr  = r_fetch_pc & ~32'h3;
    // The buffer keeps its last word after consumption; the IDU must only ever see 0 then.
    assign inst           = r_out_valid ? r_out_inst : 32'h0;
    assign pc             = r_out_pc;
    // A stalled IDU keeps its instruction, so no bubble while pipe_stop is high (unless flushing).
    assign inst_clear     = redirect_valid || (!r_out_valid && !pipe_stop);

    // Next-state and datapath updates; a redirect wins over every other event.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_inst_nxt  = r_out_inst;
        w_out_pc_nxt    = r_out_pc;
        w_drop_nxt      = r_drop;

        if (redirect_valid) begin
            w_fetch_pc_nxt  = w_redirect_aligned;
            w_out_valid_nxt = 1'b0;
            // A request still in flight must have its response swallowed; if the response
            // lands this very cycle it is already gone, so just refetch.
            if (w_handshake || (r_state == S_WAIT && !inst_rsp_valid)) begin
                w_drop_nxt  = 1'b1;
                w_state_nxt = S_WAIT;
            end else begin
                w_drop_nxt  = 1'b0;
                w_state_nxt = S_REQ;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (inst_req_ready) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_rsp_valid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = S_REQ;
                        end else begin
                            w_out_inst_nxt  = inst_rsp_data;
                            w_out_pc_nxt    = r_fetch_pc;
                            w_out_valid_nxt = 1'b1;
                            w_state_nxt     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!pipe_stop) begin
                        w_out_valid_nxt = 1'b0;
                        w_fetch_pc_nxt  = r_fetch_pc + 32'd4;
                        w_state_nxt     = S_REQ;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC & ~32'h3;
            r_out_valid <= 1'b0;
            r_out_inst  <= 32'h0;
            r_out_pc    <= 32'h0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port pipe_stop  input  1  decode-stage stall; IDU holds its instruction register when high.
REQ-005 SHALL have port redirect_valid  input  1  one-cycle pulse from branch/jump/ecall/mret resolution.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-007 SHALL have port inst_req_valid  output  1  instruction-memory request valid.
REQ-008 SHALL have port inst_req_addr  output  32  request address, word aligned.
REQ-009 SHALL have port inst_req_ready  input  1  memory accepts request; handshake = valid && ready at posedge.
REQ-010 SHALL have port inst_rsp_valid  input  1  response data valid (one cycle per accepted request).
REQ-011 SHALL have port inst_rsp_data  input  32  fetched instruction word.
REQ-012 SHALL have port inst  output  32  instruction to IDU.
REQ-013 SHALL have port pc  output  32  address of inst.
REQ-014 SHALL have port inst_clear  output  1  tells IDU to load a bubble (inst 0).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-016 SHALL keep internal fetch_pc, out_valid flag, out_inst/out_pc buffer and a drop flag.
REQ-017 SHALL drive inst_req_valid = 1 only in REQ; inst_req_addr = fetch_pc, {fetch_pc[31:2],2'b00}.
REQ-018 IDLE SHALL go to REQ unconditionally on the first cycle after reset release.
REQ-019 REQ SHALL go to WAIT on handshake, otherwise stay in REQ with address stable.
REQ-020 WAIT with inst_rsp_valid and drop=0 SHALL capture out_inst<=inst_rsp_data, out_pc<=fetch_pc, out_valid<=1, go to HOLD.
REQ-021 HOLD with pipe_stop=0 SHALL treat the buffer as consumed at that edge: out_valid<=0, fetch_pc<=fetch_pc+4 (mod 2^32), go to REQ.
REQ-022 HOLD with pipe_stop=1 SHALL hold buffer and state unchanged indefinitely.
REQ-023 inst and pc SHALL equal out_inst and out_pc at all times; inst SHALL read 0 whenever out_valid=0.
REQ-024 inst_clear SHALL equal redirect_valid || (!out_valid && !pipe_stop); a bubble SHALL never overwrite a stalled IDU instruction.
REQ-025 redirect_valid SHALL take priority over all other events: fetch_pc<=redirect_pc aligned, out_valid<=0.
REQ-026 On redirect in WAIT, or in REQ with a same-cycle handshake: drop<=1, next state WAIT.
REQ-027 On redirect in REQ without handshake, HOLD or IDLE: drop<=0, next state REQ.
REQ-028 WAIT with inst_rsp_valid and drop=1 SHALL discard the data, clear drop, go to REQ with current fetch_pc.
REQ-029 Redirect coinciding with inst_rsp_valid in WAIT SHALL discard that response and re-fetch from redirect_pc.
REQ-030 Minimum latency: request-to-inst valid = response latency + 1 cycle; steady state, one instruction per 3 cycles with 0-wait memory.

Reset
REQ-031 While rst_n=0 at a posedge: state<=IDLE, fetch_pc<=RESET_PC, out_valid<=0, out_inst<=0, out_pc<=0, drop<=0.
REQ-032 During and immediately after reset: inst_req_valid=0, inst=0, pc=0, inst_clear=1 (if pipe_stop=0).
REQ-033 Reset asserted mid-transaction SHALL abandon any outstanding request; a late response after reset release SHALL be ignored unless in WAIT.

Verification
REQ-034 Reset release, ready=1, response next cycle with 32'h00000413 -> req addr 8000_0000, inst=00000413, pc=8000_0000 two cycles after handshake; next req addr 8000_0004.
REQ-035 Instruction in HOLD, pipe_stop=1 for 5 cycles -> inst/pc constant, inst_clear=0, no new request; after release, one edge later req addr = pc+4.
REQ-036 Redirect to 8000_0100 in WAIT, then response 32'hDEADBEEF -> data discarded, inst_clear=1 on redirect cycle, next req addr 8000_0100.
REQ-037 Redirect to 8000_0203 with inst_req_ready=0 in REQ -> addr changes to 8000_0200 next cycle, drop=0.
REQ-038 fetch_pc FFFF_FFFC consumed -> next req addr 0000_0000 (wrap).
REQ-039 rst_n low during WAIT, then response arrives after release -> first request issued at RESET_PC and stale response not presented on inst.
